// File: rtl/cam_ctrl.sv
// Handshaked controller around an 8-entry content-addressable match table.
// A search registers its match vector and streams every hit, lowest address first.
module cam_ctrl #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [AW-1:0]    req_addr,
   input  logic [WIDTH-1:0] req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_hit,
   output logic [AW-1:0]    rsp_addr,
   output logic [CW-1:0]    rsp_count,
   output logic             rsp_last,
   output logic             busy
);

   localparam logic [1:0] OP_CLEAR  = 2'd0;
   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_INVAL  = 2'd2;
   localparam logic [1:0] OP_SEARCH = 2'd3;

   typedef enum logic [1:0] {IDLE, REPORT, MISS} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] mv_q, mv_nxt;
   logic [CW-1:0]    cnt_q, cnt_nxt;
   logic [DEPTH-1:0] hit_vec;
   logic [CW-1:0]    hit_cnt;
   logic [AW-1:0]    low_idx;
   logic             mv_single;
   logic             accept;
   logic             addr_ok;

   // Valid/ready: a transfer happens on any rising edge where valid && ready are both
   // high; the producer holds its payload stable until then, and ready never depends on
   // the producer's valid.
   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign addr_ok   = int'(req_addr) < DEPTH;
   assign busy      = (state != IDLE);

   always_comb begin
      hit_vec = '0;
      hit_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = valid_q[i] && (data_q[i] == req_data);
         hit_cnt    = hit_cnt + CW'(hit_vec[i]);
      end
   end

   // Scanning downward leaves the lowest set bit as the final assignment.
   always_comb begin
      low_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (mv_q[i]) low_idx = AW'(i);
      end
   end

   assign mv_single = (mv_q != '0) && ((mv_q & (mv_q - DEPTH'(1))) == '0);

   always_comb begin
      state_nxt = state;
      mv_nxt    = mv_q;
      cnt_nxt   = cnt_q;
      case (state)
         IDLE: begin
            if (accept && req_op == OP_SEARCH) begin
               mv_nxt    = hit_vec;
               cnt_nxt   = hit_cnt;
               state_nxt = (hit_cnt != '0) ? REPORT : MISS;
            end
         end
         REPORT: begin
            if (rsp_ready) begin
               mv_nxt = mv_q & (mv_q - DEPTH'(1));
               if (mv_single) state_nxt = IDLE;
            end
         end
         MISS: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = (state == REPORT) || (state == MISS);
      rsp_hit   = (state == REPORT);
      rsp_addr  = (state == REPORT) ? low_idx : '0;
      rsp_count = (state == REPORT) ? cnt_q : '0;
      rsp_last  = (state == MISS) || ((state == REPORT) && mv_single);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid_q <= '0;
         mv_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state <= state_nxt;
         mv_q  <= mv_nxt;
         cnt_q <= cnt_nxt;
         if (accept) begin
            case (req_op)
               OP_CLEAR: valid_q <= '0;
               OP_WRITE: if (addr_ok) valid_q[req_addr] <= 1'b1;
               OP_INVAL: if (addr_ok) valid_q[req_addr] <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   // Entry payloads are qualified by valid_q, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept && req_op == OP_WRITE && addr_ok) data_q[req_addr] <= req_data;
   end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed testbench for cam_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_cam_ctrl;

   localparam logic [1:0] OP_CLEAR  = 2'd0;
   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_INVAL  = 2'd2;
   localparam logic [1:0] OP_SEARCH = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [2:0]  req_addr = 3'd0;
   logic [15:0] req_data = 16'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_hit;
   logic [2:0]  rsp_addr;
   logic [3:0]  rsp_count;
   logic        rsp_last;
   logic        busy;

   int checks = 0;
   int errors = 0;

   cam_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_addr  (rsp_addr),
      .rsp_count (rsp_count),
      .rsp_last  (rsp_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Drive one request from a falling edge; returns on the falling edge after acceptance.
   task automatic do_req(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] data);
      int n;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_data  = data;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic expect_beat(input string name, input logic hit, input logic [2:0] addr,
                              input logic [3:0] cnt, input logic last);
      checks++;
      if ({rsp_valid, rsp_hit, rsp_addr, rsp_count, rsp_last} !== {1'b1, hit, addr, cnt, last}) begin
         errors++;
         $display("FAIL %s: got v=%b hit=%b addr=%0d cnt=%0d last=%b, required v=1 hit=%b addr=%0d cnt=%0d last=%b",
                  name, rsp_valid, rsp_hit, rsp_addr, rsp_count, rsp_last, hit, addr, cnt, last);
      end
      @(negedge clk);
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL %s: got rsp_valid=%b busy=%b req_ready=%b, required 0 0 1",
                  name, rsp_valid, busy, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_hit, rsp_addr, rsp_count, rsp_last, busy, req_ready} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b hit=%b addr=%0d cnt=%0d last=%b busy=%b rdy=%b, required all 0",
                  rsp_valid, rsp_hit, rsp_addr, rsp_count, rsp_last, busy, req_ready);
      end
      rst = 1'b0;
      #1;
      check_idle("reset_release");
      @(negedge clk);
   endtask

   task automatic test_empty_miss();
      do_req(OP_SEARCH, 3'd0, 16'h0000);
      expect_beat("empty_miss", 1'b0, 3'd0, 4'd0, 1'b1);
      check_idle("empty_miss_idle");
   endtask

   task automatic test_multi_match();
      do_req(OP_WRITE, 3'd0, 16'h0001);
      do_req(OP_WRITE, 3'd1, 16'h0002);
      do_req(OP_WRITE, 3'd5, 16'h0002);
      do_req(OP_WRITE, 3'd7, 16'h0009);
      do_req(OP_SEARCH, 3'd0, 16'h0002);
      expect_beat("multi_beat1", 1'b1, 3'd1, 4'd2, 1'b0);
      expect_beat("multi_beat2", 1'b1, 3'd5, 4'd2, 1'b1);
      check_idle("multi_idle");
   endtask

   task automatic test_backpressure();
      do_req(OP_SEARCH, 3'd0, 16'h0002);
      rsp_ready = 1'b0;
      // A write held pending across the stall must wait for IDLE.
      req_valid = 1'b1;
      req_op    = OP_WRITE;
      req_addr  = 3'd3;
      req_data  = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rsp_valid, rsp_hit, rsp_addr, rsp_count, rsp_last, req_ready, busy} !== {1'b1, 1'b1, 3'd1, 4'd2, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b addr=%0d cnt=%0d last=%b rdy=%b busy=%b, required 1 1 2 0 0 1",
                     i, rsp_valid, rsp_addr, rsp_count, rsp_last, req_ready, busy);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      expect_beat("stall_beat1", 1'b1, 3'd1, 4'd2, 1'b0);
      expect_beat("stall_beat2", 1'b1, 3'd5, 4'd2, 1'b1);
      check_idle("stall_idle");
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_invalidate();
      do_req(OP_INVAL, 3'd1, 16'h0000);
      do_req(OP_SEARCH, 3'd0, 16'h0002);
      expect_beat("inval_single", 1'b1, 3'd5, 4'd1, 1'b1);
      do_req(OP_WRITE, 3'd5, 16'h0003);
      do_req(OP_SEARCH, 3'd0, 16'h0002);
      expect_beat("overwrite_miss", 1'b0, 3'd0, 4'd0, 1'b1);
      do_req(OP_SEARCH, 3'd0, 16'h1234);
      expect_beat("pending_write", 1'b1, 3'd3, 4'd1, 1'b1);
   endtask

   task automatic test_back_to_back_full();
      for (int i = 0; i < 8; i++) do_req(OP_WRITE, 3'(i), 16'h00AA);
      do_req(OP_SEARCH, 3'd0, 16'h00AA);
      for (int i = 0; i < 8; i++) expect_beat("full_beat", 1'b1, 3'(i), 4'd8, i == 7);
      check_idle("full_idle");
   endtask

   task automatic test_clear();
      do_req(OP_CLEAR, 3'd0, 16'h0000);
      do_req(OP_SEARCH, 3'd0, 16'h00AA);
      expect_beat("clear_miss", 1'b0, 3'd0, 4'd0, 1'b1);
   endtask

   task automatic test_reset_abort();
      for (int i = 0; i < 8; i++) do_req(OP_WRITE, 3'(i), 16'h00AA);
      do_req(OP_SEARCH, 3'd0, 16'h00AA);
      expect_beat("abort_beat1", 1'b1, 3'd0, 4'd8, 1'b0);
      expect_beat("abort_beat2", 1'b1, 3'd1, 4'd8, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL abort_reset: got rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
      end
      rst = 1'b0;
      do_req(OP_SEARCH, 3'd0, 16'h00AA);
      expect_beat("abort_miss", 1'b0, 3'd0, 4'd0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_empty_miss();
      test_multi_match();
      test_backpressure();
      test_invalidate();
      test_back_to_back_full();
      test_clear();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
